// File: rtl/fft_iterative_pkg.sv
// Shared types, Q16.16 twiddle table and index helpers
// for the in-place iterative radix-2 FFT.
package fft_iterative_pkg;

    localparam int FRAC_W  = 16;
    localparam int TW_SIZE = 32;

    typedef struct packed {
        logic signed [31:0] real_part;
        logic signed [31:0] imag_part;
    } complex_number_t;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } fft_state_t;

    // cos/sin(2*pi*k/64), k = 0..31, rounded to Q16.16
    localparam int TW_COS [TW_SIZE] = '{
        65536,  65220,  64277,  62714,  60547,  57798,  54491,  50660,
        46341,  41576,  36410,  30893,  25080,  19024,  12785,   6424,
            0,  -6424, -12785, -19024, -25080, -30893, -36410, -41576,
       -46341, -50660, -54491, -57798, -60547, -62714, -64277, -65220
    };

    localparam int TW_SIN [TW_SIZE] = '{
            0,   6424,  12785,  19024,  25080,  30893,  36410,  41576,
        46341,  50660,  54491,  57798,  60547,  62714,  64277,  65220,
        65536,  65220,  64277,  62714,  60547,  57798,  54491,  50660,
        46341,  41576,  36410,  30893,  25080,  19024,  12785,   6424
    };

    function automatic complex_number_t twiddle(
        input logic [4:0] idx,
        input logic       conj
    );
        complex_number_t w;
        w.real_part = TW_COS[idx];
        w.imag_part = conj ? TW_SIN[idx] : -TW_SIN[idx];
        return w;
    endfunction

    // Reverses the low 'bits' bits of value; result sits in the low bits.
    function automatic logic [5:0] bitrev(
        input logic [5:0] value,
        input int         bits
    );
        logic [5:0] v;
        logic [5:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < bits) begin
                r = {r[4:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_iterative_bfly.sv
// Radix-2 DIT butterfly: a' = a + W*b, b' = a - W*b,
// truncating complex multiply, optional halving for the inverse.
module fft_bfly
    import fft_iterative_pkg::*;
#(
    parameter int FRAC_W = fft_iterative_pkg::FRAC_W
) (
    input  complex_number_t a,
    input  complex_number_t b,
    input  complex_number_t w,
    input  logic            inverse,
    output complex_number_t a_res,
    output complex_number_t b_res
);

    logic signed [63:0] w_re;
    logic signed [63:0] w_im;
    logic signed [63:0] b_re;
    logic signed [63:0] b_im;
    logic signed [63:0] prod_re;
    logic signed [63:0] prod_im;
    complex_number_t    wb;
    complex_number_t    sum;
    complex_number_t    diff;

    assign w_re = {{32{w.real_part[31]}}, w.real_part};
    assign w_im = {{32{w.imag_part[31]}}, w.imag_part};
    assign b_re = {{32{b.real_part[31]}}, b.real_part};
    assign b_im = {{32{b.imag_part[31]}}, b.imag_part};

    assign prod_re = w_re * b_re - w_im * b_im;
    assign prod_im = w_re * b_im + w_im * b_re;

    always_comb begin
        wb.real_part   = 32'(prod_re >>> FRAC_W);
        wb.imag_part   = 32'(prod_im >>> FRAC_W);
        sum.real_part  = a.real_part + wb.real_part;
        sum.imag_part  = a.imag_part + wb.imag_part;
        diff.real_part = a.real_part - wb.real_part;
        diff.imag_part = a.imag_part - wb.imag_part;
        a_res = sum;
        b_res = diff;
        // Halving every stage gives the 1/N scale of the inverse.
        if (inverse) begin
            a_res.real_part = $signed(sum.real_part) >>> 1;
            a_res.imag_part = $signed(sum.imag_part) >>> 1;
            b_res.real_part = $signed(diff.real_part) >>> 1;
            b_res.imag_part = $signed(diff.imag_part) >>> 1;
        end
    end

endmodule

// File: rtl/fft_iterative.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load,
// one butterfly per cycle, natural-order unload.
module fft_iterative
    import fft_iterative_pkg::*;
#(
    parameter int N_POINT = 8,
    parameter int FRAC_W  = fft_iterative_pkg::FRAC_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  complex_number_t            in_data,
    input  logic                       inverse,
    output logic                       out_valid,
    input  logic                       out_ready,
    output complex_number_t            out_data,
    output logic [$clog2(N_POINT)-1:0] out_index,
    output logic                       busy
);

    localparam int S      = $clog2(N_POINT);
    localparam int AW     = S;
    localparam int HALF_N = N_POINT / 2;

    fft_state_t      state;
    fft_state_t      state_next;
    complex_number_t buffer [N_POINT];

    logic [AW-1:0] count;
    logic [AW-1:0] out_cnt;
    logic [AW-1:0] group;
    logic [AW-1:0] bfly;
    logic [2:0]    stage;
    logic          inv_q;

    logic          in_hs;
    logic          out_hs;
    logic [AW-1:0] half;
    logic [AW-1:0] groups;
    logic          bfly_last;
    logic          group_last;
    logic          stage_last;
    logic          compute_done;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] idx_a;
    logic [AW-1:0] idx_b;
    logic [4:0]    tw_idx;

    complex_number_t w;
    complex_number_t a_res;
    complex_number_t b_res;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == UNLOAD);
    assign busy      = (state != LOAD);
    assign out_index = out_cnt;
    assign out_data  = out_valid ? buffer[out_cnt] : '0;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    assign half       = AW'(1) << stage;
    assign groups     = AW'(HALF_N) >> stage;
    assign bfly_last  = (bfly == half - AW'(1));
    assign group_last = (group == groups - AW'(1));
    assign stage_last = (stage == 3'(S - 1));
    assign compute_done = (state == COMPUTE) && bfly_last
                       && group_last && stage_last;

    assign load_addr = AW'(bitrev(6'(count), S));

    // Span of stage s is 2^(s+1); twiddle stride in the N=64 table
    // is 64/span, i.e. a left shift of the butterfly index by 5-s.
    assign idx_a  = (group << (stage + 3'd1)) | bfly;
    assign idx_b  = idx_a + half;
    assign tw_idx = 5'(6'(bfly) << (3'd5 - stage));
    assign w      = twiddle(tw_idx, inv_q);

    fft_bfly #(
        .FRAC_W (FRAC_W)
    ) u_bfly (
        .a       (buffer[idx_a]),
        .b       (buffer[idx_b]),
        .w       (w),
        .inverse (inv_q),
        .a_res   (a_res),
        .b_res   (b_res)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD: begin
                if (in_hs && count == AW'(N_POINT - 1))
                    state_next = COMPUTE;
            end
            COMPUTE: begin
                if (compute_done)
                    state_next = UNLOAD;
            end
            UNLOAD: begin
                if (out_hs && out_cnt == AW'(N_POINT - 1))
                    state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= LOAD;
            count   <= '0;
            out_cnt <= '0;
            stage   <= '0;
            group   <= '0;
            bfly    <= '0;
            inv_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (in_hs) begin
                count <= count + AW'(1);
                if (count == '0)
                    inv_q <= inverse;
            end
            if (state == COMPUTE) begin
                if (bfly_last) begin
                    bfly <= '0;
                    if (group_last) begin
                        group <= '0;
                        stage <= stage_last ? 3'd0 : stage + 3'd1;
                    end else begin
                        group <= group + AW'(1);
                    end
                end else begin
                    bfly <= bfly + AW'(1);
                end
            end
            if (out_hs)
                out_cnt <= out_cnt + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (in_hs) begin
            buffer[load_addr] <= in_data;
        end else if (state == COMPUTE) begin
            buffer[idx_a] <= a_res;
            buffer[idx_b] <= b_res;
        end
    end

endmodule

// File: tb/tb_fft_iterative.sv
// Scoreboard bench for fft_iterative: floating-point DFT model,
// backpressure, mid-frame reset and an N=16 instance.
module tb_fft_iterative;
    import fft_iterative_pkg::*;

    typedef struct {
        complex_number_t d;
        int              tol;
    } exp_t;

    localparam real PI = 3.14159265358979;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic            in_valid = 1'b0;
    logic            in_ready;
    complex_number_t in_data = '0;
    logic            inverse = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    complex_number_t out_data;
    logic [2:0]      out_index;
    logic            busy;

    logic            in_valid16 = 1'b0;
    logic            in_ready16;
    complex_number_t in_data16 = '0;
    logic            inverse16 = 1'b0;
    logic            out_valid16;
    logic            out_ready16 = 1'b1;
    complex_number_t out_data16;
    logic [3:0]      out_index16;
    logic            busy16;

    int total = 0;
    int bad   = 0;
    bit bp    = 1'b0;

    exp_t            exp_q [$];
    exp_t            exp16_q [$];
    complex_number_t got_q [$];
    complex_number_t frame [64];
    complex_number_t orig [8];

    always #5 clock = ~clock;

    fft_iterative #(.N_POINT(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .inverse   (inverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy)
    );

    fft_iterative #(.N_POINT(16)) dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .inverse   (inverse16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .out_index (out_index16),
        .busy      (busy16)
    );

    task automatic check(input bit ok, input string name,
                         input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_cplx(input string name,
                              input complex_number_t act, input exp_t e);
        longint ar, ai, er, ei;
        ar = longint'($signed(act.real_part));
        ai = longint'($signed(act.imag_part));
        er = longint'($signed(e.d.real_part));
        ei = longint'($signed(e.d.imag_part));
        check((ar - er <= e.tol) && (er - ar <= e.tol),
              {name, ".re"}, ar, er);
        check((ai - ei <= e.tol) && (ei - ai <= e.tol),
              {name, ".im"}, ai, ei);
    endtask

    // Direct DFT of frame[0..npt-1]; inverse uses e^{+j} and 1/N.
    function automatic complex_number_t dft_bin(input int k, input int npt,
                                                input bit inv);
        real re, im, ang, xr, xi;
        complex_number_t r;
        re = 0.0;
        im = 0.0;
        for (int n = 0; n < npt; n++) begin
            ang = 2.0 * PI * $itor((k * n) % npt) / $itor(npt);
            if (!inv) ang = -ang;
            xr = $itor($signed(frame[n].real_part));
            xi = $itor($signed(frame[n].imag_part));
            re = re + xr * $cos(ang) - xi * $sin(ang);
            im = im + xr * $sin(ang) + xi * $cos(ang);
        end
        if (inv) begin
            re = re / $itor(npt);
            im = im / $itor(npt);
        end
        r.real_part = $rtoi(re >= 0.0 ? re + 0.5 : re - 0.5);
        r.imag_part = $rtoi(im >= 0.0 ? im + 0.5 : im - 0.5);
        return r;
    endfunction

    function automatic logic signed [31:0] rnd_comp();
        return 32'(int'($urandom_range(0, 131072)) - 65536);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_frame();
        for (int n = 0; n < 64; n++) frame[n] = '0;
    endtask

    task automatic random_frame(input int npt);
        for (int n = 0; n < npt; n++) begin
            frame[n].real_part = rnd_comp();
            frame[n].imag_part = rnd_comp();
        end
    endtask

    task automatic push_model(input int tol, input bit inv);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.d   = dft_bin(k, 8, inv);
            e.tol = tol;
            exp_q.push_back(e);
        end
    endtask

    task automatic load_frame(input bit inv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check(in_ready, "in_ready_before_frame", longint'(in_ready), 1);
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                inverse  = !inv;
                tick();
            end
            in_valid = 1'b1;
            in_data  = frame[n];
            inverse  = (n == 0) ? inv : !inv;
            tick();
        end
        in_valid = 1'b0;
        inverse  = 1'b0;
    endtask

    // Garbage on in_valid while busy must be ignored.
    task automatic await_output();
        int c;
        c = 0;
        in_valid = 1'b1;
        while (!out_valid && c < 200) begin
            in_data.real_part = rnd_comp();
            in_data.imag_part = rnd_comp();
            tick();
            c++;
        end
        in_valid = 1'b0;
        check(c == 12, "latency8", c, 12);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            tick();
            c++;
        end
        check(exp_q.size() == 0, "drain8", exp_q.size(), 0);
        tick();
    endtask

    task automatic run16(input int tol);
        exp_t e;
        int   c;
        for (int k = 0; k < 16; k++) begin
            e.d   = dft_bin(k, 16, 1'b0);
            e.tol = tol;
            exp16_q.push_back(e);
        end
        c = 0;
        while (!in_ready16 && c < 200) begin
            tick();
            c++;
        end
        for (int n = 0; n < 16; n++) begin
            in_valid16 = 1'b1;
            in_data16  = frame[n];
            tick();
        end
        in_valid16 = 1'b0;
        c = 0;
        while (!out_valid16 && c < 200) begin
            tick();
            c++;
        end
        check(c == 32, "latency16", c, 32);
        c = 0;
        while (exp16_q.size() != 0 && c < 200) begin
            tick();
            c++;
        end
        check(exp16_q.size() == 0, "drain16", exp16_q.size(), 0);
        tick();
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int              exp_idx = 0;
    bit              stalled = 1'b0;
    bit              chk_ready = 1'b0;
    complex_number_t held_data;
    logic [2:0]      held_idx;
    exp_t            mon_e;

    always @(negedge clock) begin
        if (reset) begin
            exp_idx   = 0;
            stalled   = 1'b0;
            chk_ready = 1'b0;
        end else begin
            if (chk_ready) begin
                check(in_ready, "in_ready_after_last",
                      longint'(in_ready), 1);
                chk_ready = 1'b0;
            end
            if (out_valid) begin
                if (stalled) begin
                    check(out_data == held_data, "stall_data",
                          longint'($signed(out_data.real_part)),
                          longint'($signed(held_data.real_part)));
                    check(out_index == held_idx, "stall_index",
                          longint'(out_index), longint'(held_idx));
                end
                check(exp_q.size() != 0, "spurious_out_valid",
                      longint'(out_index), -1);
                if (out_ready && exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_cplx($sformatf("bin8[%0d]", exp_idx),
                               out_data, mon_e);
                    check(out_index == 3'(exp_idx), "out_index8",
                          longint'(out_index), exp_idx);
                    got_q.push_back(out_data);
                    if (out_index == 3'd7) chk_ready = 1'b1;
                    exp_idx = (exp_idx + 1) % 8;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = out_data;
                    held_idx  = out_index;
                end
            end
        end
    end

    int   exp16_idx = 0;
    exp_t mon16_e;

    always @(negedge clock) begin
        if (reset) begin
            exp16_idx = 0;
        end else if (out_valid16) begin
            check(exp16_q.size() != 0, "spurious_out_valid16",
                  longint'(out_index16), -1);
            if (exp16_q.size() != 0) begin
                mon16_e = exp16_q.pop_front();
                check_cplx($sformatf("bin16[%0d]", exp16_idx),
                           out_data16, mon16_e);
                check(out_index16 == 4'(exp16_idx), "out_index16",
                      longint'(out_index16), exp16_idx);
                exp16_idx = (exp16_idx + 1) % 16;
            end
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);
        check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
        check(busy == 1'b0, "rst_busy", longint'(busy), 0);
        check(out_index == 3'd0, "rst_out_index", longint'(out_index), 0);
        check(out_data == '0, "rst_out_data",
              longint'($signed(out_data.real_part)), 0);
        check(in_ready16 == 1'b1, "rst_in_ready16", longint'(in_ready16), 1);

        clear_frame();
        frame[0].real_part = 32'h0001_0000;
        push_model(0, 1'b0);
        load_frame(1'b0);
        await_output();
        wait_drain();

        for (int n = 0; n < 8; n++) frame[n].real_part = 32'h0001_0000;
        push_model(4, 1'b0);
        load_frame(1'b0);
        await_output();
        wait_drain();

        clear_frame();
        frame[1].real_part = 32'h0001_0000;
        push_model(4, 1'b0);
        load_frame(1'b0);
        await_output();
        wait_drain();

        clear_frame();
        frame[0].real_part = 32'h0008_0000;
        push_model(4, 1'b1);
        load_frame(1'b1);
        await_output();
        wait_drain();

        random_frame(8);
        for (int n = 0; n < 8; n++) orig[n] = frame[n];
        got_q.delete();
        push_model(16, 1'b0);
        load_frame(1'b0);
        await_output();
        wait_drain();
        check(got_q.size() == 8, "roundtrip_capture", got_q.size(), 8);
        for (int n = 0; n < 8; n++) begin
            frame[n] = (n < got_q.size()) ? got_q[n] : '0;
            e.d   = orig[n];
            e.tol = 8;
            exp_q.push_back(e);
        end
        load_frame(1'b1);
        await_output();
        wait_drain();

        bp = 1'b1;
        repeat (2) begin
            random_frame(8);
            push_model(16, 1'b0);
            load_frame(1'b0);
            await_output();
            wait_drain();
        end
        bp = 1'b0;
        tick();

        clear_frame();
        frame[0].real_part = 32'h0001_0000;
        load_frame(1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check(in_ready == 1'b1, "midrst_in_ready", longint'(in_ready), 1);
        check(busy == 1'b0, "midrst_busy", longint'(busy), 0);
        check(out_valid == 1'b0, "midrst_out_valid", longint'(out_valid), 0);
        check(out_index == 3'd0, "midrst_out_index", longint'(out_index), 0);
        check(out_data == '0, "midrst_out_data",
              longint'($signed(out_data.real_part)), 0);
        repeat (30) tick();
        check(out_valid == 1'b0, "midrst_quiet", longint'(out_valid), 0);

        clear_frame();
        frame[0].real_part = 32'h0001_0000;
        run16(0);
        random_frame(16);
        run16(32);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_iterative.md
FFT_ITERATIVE -- requirements
Module: fft_iterative

Interface
REQ-001 The block SHALL have parameter N_POINT, default 8, meaning the transform size; it SHALL be a power of two in the range 4..64.
REQ-002 The block SHALL have parameter FRAC_W, default 16, meaning the fractional bits of each 32-bit signed fixed-point component.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a sample
- in_data  in  COMPLEX_NUMBER  time-domain sample, natural order
- inverse  in  1  frame mode, sampled with sample 0
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  COMPLEX_NUMBER  frequency-domain result
- out_index  out  log2(N_POINT)  bin index of out_data
- busy  out  1  high in COMPUTE or UNLOAD

Function
REQ-005 The FSM SHALL have three states: LOAD (entered at reset), COMPUTE and UNLOAD.
REQ-006 In LOAD, in_ready SHALL be 1; each in_valid&in_ready edge SHALL write in_data to buffer[bitrev(count)] and increment count.
REQ-007 The inverse input SHALL be latched on the sample-0 handshake and held for the whole frame.
REQ-008 On the handshake of sample N_POINT-1, the FSM SHALL enter COMPUTE on the same edge, and in_ready SHALL fall to 0.
REQ-009 COMPUTE SHALL execute S = log2(N_POINT) stages of N_POINT/2 radix-2 DIT butterflies, one butterfly per cycle, for exactly S·N_POINT/2 cycles (12 for N=8).
REQ-010 Each butterfly step SHALL read two buffer entries combinationally and write both results back in place on the same edge.
REQ-011 Butterfly arithmetic SHALL compute a' = a + W·b and b' = a - W·b.
REQ-012 W = W_N^k SHALL equal cos(2πk/N) - j·sin(2πk/N) in Q16.16 when inverse=0, and its conjugate when inverse=1.
REQ-013 Complex multiplication SHALL form 64-bit products, sum them, and take bits [FRAC_W+31:FRAC_W] (truncation).
REQ-014 Additions SHALL wrap in two's complement, with no saturation.
REQ-015 When inverse=1, each butterfly output SHALL be arithmetically shifted right by 1, giving a 1/N overall scale.
REQ-016 out_valid SHALL rise exactly S·N_POINT/2 edges after the edge that accepted sample N_POINT-1.
REQ-017 In UNLOAD, out_data SHALL equal buffer[out_index], with out_index counting 0..N_POINT-1 in natural order.
REQ-018 out_data and out_index SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 The handshake of out_index=N_POINT-1 SHALL return the FSM to LOAD on the same edge, with in_ready=1 the next cycle.
REQ-020 Frames SHALL NOT overlap.
REQ-021 in_valid SHALL be ignored outside LOAD.
REQ-022 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-023 On reset, the state SHALL be LOAD and all counters SHALL be 0.
REQ-024 Reset output values SHALL be: in_ready=1, out_valid=0, busy=0, out_index=0, out_data=0.
REQ-025 The buffer contents SHALL NOT be reset.
REQ-026 Reset asserted during any state SHALL abandon the frame; the next cycle SHALL show the reset output values.

Structure
REQ-027 The shared package SHALL hold the COMPLEX_NUMBER typedef (32-bit real_part/imag_part), FRAC_W, and a 32-entry Q16.16 twiddle table for N=64.
REQ-028 For smaller N, twiddle k SHALL be read from table index k·(64/N_POINT).
REQ-029 The package SHALL hold a bitrev function.
REQ-030 The combinational sub-module fft_bfly SHALL implement REQ-011 through REQ-015 (inputs a, b, w, inverse; outputs a', b').
REQ-031 Addressing SHALL be generated from stage/group/butterfly counters.

Verification
REQ-032 The bench SHALL cover an impulse: N=8, x[0]=1.0 (0x00010000), rest 0 -> all X[k]=1.0+0j.
REQ-033 The bench SHALL cover DC: N=8, all x=1.0 -> X[0]=8.0 (0x00080000), X[1..7]=0, within ±4 LSB.
REQ-034 The bench SHALL cover a shifted impulse: N=8, x[1]=1.0 -> X[k]=W8^k, e.g. X[1]=0x0000B505 - j·0x0000B505 within ±4 LSB.
REQ-035 The bench SHALL cover inverse mode: inverse=1, input X[0]=8.0, rest 0 -> all x=1.0; a forward then inverse round trip on a random frame SHALL match within ±8 LSB.
REQ-036 The bench SHALL cover backpressure: out_ready toggled randomly -> outputs stable while stalled, indices 0..7 each exactly once, and in_ready high the cycle after index 7.
REQ-037 The bench SHALL cover reset mid-COMPUTE: reset asserted at compute cycle 5 -> next cycle in_ready=1, busy=0, and no out_valid; the bench SHALL then run a full N=16 impulse frame to check parameterisation.
